// File: rtl/alucont_mc.sv
// alucont_mc: ALU control decoder with an attached iterative unsigned
// multiply/divide unit (multu/divu).
//
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   start           - request; aluop/funct/a/b are sampled on this cycle's edge
//   aluop [1:0]     - main-decoder ALU op class
//   funct [5:0]     - R-format function field
//   a, b  [WIDTH]   - operands for multu/divu
//   gout  [CTRL_W]  - ALU control code, purely combinational from aluop/funct
//   illegal         - aluop=10 with a funct that has no defined decode
//   busy            - multiply/divide iterations in progress
//   done            - one-cycle pulse: hi/lo were just written
//   hi, lo [WIDTH]  - registered multiply/divide results
module alucont_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [CTRL_W-1:0] gout,
  output logic              illegal,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state_q, state_d;
  // Shared accumulator: MUL holds {partial product hi, multiplier remaining};
  // DIV holds {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               start_mul, start_div, last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_sub;

  // Control-code decode; deliberately independent of FSM state.
  always_comb begin
    gout    = CTRL_W'(5'b00010);
    illegal = 1'b0;
    case (aluop)
      2'b00: gout = CTRL_W'(5'b00010);
      2'b01: gout = CTRL_W'(5'b01010);
      2'b11: gout = CTRL_W'(5'b11000);
      default: begin
        case (funct)
          6'b100000:   gout = CTRL_W'(5'b00010);
          6'b100010:   gout = CTRL_W'(5'b01010);
          6'b100100:   gout = CTRL_W'(5'b00000);
          6'b100101:   gout = CTRL_W'(5'b00001);
          6'b101010:   gout = CTRL_W'(5'b01011);
          6'b000010:   gout = CTRL_W'(5'b00100);
          FUNCT_MULTU: gout = CTRL_W'(5'b00010);
          FUNCT_DIVU:  gout = CTRL_W'(5'b00010);
          default: begin
            gout    = CTRL_W'(5'b00010);
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign start_mul = start && (aluop == 2'b10) && (funct == FUNCT_MULTU);
  assign start_div = start && (aluop == 2'b10) && (funct == FUNCT_DIVU);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // FSM next state: starts are only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mul)      state_d = MUL;
        else if (start_div) state_d = DIV;
      end
      MUL, DIV: if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right (carry in).
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Restoring step: the remainder stays below the divisor, so the shifted
  // value fits WIDTH+1 bits and the difference, when taken, fits WIDTH bits.
  // A zero divisor always "fits", which yields all-ones quotient and rem=a.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = WIDTH'(div_shift - {1'b0, opnd_q});

  // Datapath: operand capture, one iteration per cycle, result writeback.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mul) begin
          acc_d  = {{WIDTH{1'b0}}, b};
          opnd_d = a;
          cnt_d  = '0;
        end else if (start_div) begin
          acc_d  = {{WIDTH{1'b0}}, a};
          opnd_d = b;
          cnt_d  = '0;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      DIV: begin
        acc_d = {(div_fits ? div_sub : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_fits};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
    if ((state_q != IDLE) && last_iter) begin
      hi_d   = acc_d[2*WIDTH-1:WIDTH];
      lo_d   = acc_d[WIDTH-1:0];
      done_d = 1'b1;
    end
  end

  // State register; reset aborts any operation and clears results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alucont_mc.sv
// Testbench for alucont_mc (WIDTH=32): decode table sweep, directed
// multu/divu sequences, reset abort, and randomized multiply/divide checked
// against arithmetic reference results.
module tb_alucont_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  logic [W-1:0]  a, b;
  logic [4:0]    gout;
  logic          illegal, busy, done;
  logic [W-1:0]  hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected hi/lo as last produced by the reference model.
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [4:0] gout;
    logic       illegal;
  } dec_vec_t;

  dec_vec_t vecs[36];

  logic [5:0] funct_list[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000010, 6'b011001, 6'b011011,
                                6'b111111};
  logic [4:0] r_code_list[9] = '{5'b00010, 5'b01010, 5'b00000, 5'b00001,
                                 5'b01011, 5'b00100, 5'b00010, 5'b00010,
                                 5'b00010};

  alucont_mc #(.WIDTH(W), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .gout(gout), .illegal(illegal), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference decode built from the op-class / funct code table.
  function automatic void refDecode(input logic [1:0] op, input logic [5:0] fn,
                                    output logic [4:0] g, output logic ill);
    g   = 5'b00010;
    ill = 1'b0;
    if (op == 2'b01) g = 5'b01010;
    else if (op == 2'b11) g = 5'b11000;
    else if (op == 2'b10) begin
      ill = 1'b1;
      for (int i = 0; i < 8; i++)
        if (fn == funct_list[i]) begin
          g   = r_code_list[i];
          ill = 1'b0;
        end
    end
  endfunction

  task automatic applyStimulus(input logic s, input logic [1:0] op,
                               input logic [5:0] fn, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
    start = s;
    aluop = op;
    funct = fn;
    a     = av;
    b     = bv;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Run one multu/divu from the current negedge. Checks busy/done timing and
  // hi/lo hold for every cycle, decode while busy, and the final result.
  // Operands are scrambled right after acceptance; optionally a divu start
  // is injected mid-operation and must be ignored. Ends in the done cycle.
  task automatic runOp(input bit is_div, input logic [W-1:0] op_a,
                       input logic [W-1:0] op_b, input bit inject,
                       input string name);
    logic [63:0] expected;
    logic [4:0]  eg;
    logic        ei;
    bit          timing_ok;
    if (is_div)
      expected = (op_b == 0) ? {op_a, {W{1'b1}}}
                             : {op_a % op_b, op_a / op_b};
    else
      expected = 64'(op_a) * 64'(op_b);
    applyStimulus(1'b1, 2'b10, is_div ? 6'b011011 : 6'b011001, op_a, op_b);
    @(posedge clk);
    @(negedge clk);
    timing_ok = (busy === 1'b1) && (done === 1'b0) &&
                (hi === model_hi) && (lo === model_lo);
    applyStimulus(1'b0, 2'($urandom), 6'($urandom), $urandom, $urandom);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (k < W && ((busy !== 1'b1) || (done !== 1'b0) ||
                    (hi !== model_hi) || (lo !== model_lo)))
        timing_ok = 0;
      if (inject && k == 10)
        applyStimulus(1'b1, 2'b10, 6'b011011, $urandom, $urandom);
      if (inject && k == 11) start = 1'b0;
      if (k == 16) begin
        #1;
        refDecode(aluop, funct, eg, ei);
        checkOutput({name, " decode while busy"}, {gout, illegal}, {eg, ei});
      end
    end
    checkOutput({name, " busy/done/hold timing"}, 64'(timing_ok), 64'd1);
    checkOutput({name, " busy after"}, 64'(busy), 64'd0);
    checkOutput({name, " done pulse"}, 64'(done), 64'd1);
    checkOutput({name, " hi"}, 64'(hi), 64'(expected[63:32]));
    checkOutput({name, " lo"}, 64'(lo), 64'(expected[31:0]));
    model_hi = expected[63:32];
    model_lo = expected[31:0];
  endtask

  initial begin
    bit          quiet_ok;
    logic [W-1:0] ra, rb;

    // Build the decode table: every op class against every listed funct.
    for (int op = 0; op < 4; op++)
      for (int i = 0; i < 9; i++) begin
        vecs[op*9+i].aluop   = 2'(op);
        vecs[op*9+i].funct   = funct_list[i];
        vecs[op*9+i].gout    = (op == 0) ? 5'b00010 :
                               (op == 1) ? 5'b01010 :
                               (op == 3) ? 5'b11000 : r_code_list[i];
        vecs[op*9+i].illegal = (op == 2) && (i == 8);
      end

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'b0, '0, '0);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep with start low so nothing launches.
    for (int i = 0; i < 36; i++) begin
      applyStimulus(1'b0, vecs[i].aluop, vecs[i].funct, '0, '0);
      #1;
      checkOutput($sformatf("decode aluop=%b funct=%b", vecs[i].aluop,
                            vecs[i].funct),
                  {gout, illegal}, {vecs[i].gout, vecs[i].illegal});
    end

    // Starts that are not multu/divu must not launch the FSM.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 6'b100000, 32'd5, 32'd6);
    @(negedge clk);
    checkOutput("start add ignored", 64'(busy), 64'd0);
    applyStimulus(1'b1, 2'b00, 6'b011001, 32'd5, 32'd6);
    @(negedge clk);
    checkOutput("start aluop00 multu ignored", 64'(busy), 64'd0);
    start = 1'b0;

    // Directed sequences.
    runOp(1'b0, 32'd7, 32'd6, 1'b1, "multu 7*6");
    runOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu max*max");
    runOp(1'b1, 32'd100, 32'd7, 1'b0, "divu 100/7 back-to-back");
    runOp(1'b1, 32'h12345678, 32'd0, 1'b0, "divu by zero");

    // Reset in the middle of a multiply with an ignored divu start.
    applyStimulus(1'b1, 2'b10, 6'b011001, 32'h0000ABCD, 32'h00001234);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) applyStimulus(1'b1, 2'b10, 6'b011011, 32'd9, 32'd3);
      if (k == 11) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort hi/lo", {hi, lo}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((done !== 1'b0) || (busy !== 1'b0) || (hi !== '0) || (lo !== '0))
        quiet_ok = 0;
    end
    checkOutput("no done after abort", 64'(quiet_ok), 64'd1);

    // Start accepted on the very first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runOp(1'b0, 32'd3, 32'd11, 1'b0, "multu right after reset");

    // Randomized multu/divu, including small operands and zero divisors.
    for (int t = 0; t < 16; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 4 == 1) rb = $urandom_range(0, 15);
      if (t % 8 == 3) rb = '0;
      runOp(1'($urandom), ra, rb, 1'(t % 2), $sformatf("random op %0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
